// File: rtl/tpu_dma_pkg.sv
// Shared definitions for the TPU output-store DMA path: FSM state encoding,
// write-control / descriptor field offsets and DMA size codes.
package tpu_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_FIN  = 2'd3
    } store_state_t;

    // write_ctrl_data = {size[2:0], length[31:0], index[31:0]}
    localparam int CTRL_W        = 67;
    localparam int CTRL_IDX_LSB  = 0;
    localparam int CTRL_LEN_LSB  = 32;
    localparam int CTRL_SIZE_LSB = 64;

    // conf_regs = {length[31:0], bram_base[31:0], index[31:0]}
    localparam int CONF_IDX_LSB  = 0;
    localparam int CONF_BASE_LSB = 32;
    localparam int CONF_LEN_LSB  = 64;

    // Platform size code for 32-bit beats
    localparam logic [2:0] DMA_SIZE_32BIT = 3'b001;

    function automatic logic [31:0] burst_min(input logic [31:0] rem,
                                              input logic [31:0] max_b);
        return (rem < max_b) ? rem : max_b;
    endfunction

endpackage

// File: rtl/store_skid_fifo.sv
// Two-entry FIFO holding prefetched BRAM words ahead of the DMA write channel.
// Push and pop in the same cycle leave the occupancy unchanged.
module store_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates their use
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/store_output_dma.sv
// DMA store engine: copies a block from the output BRAM to memory as a series
// of write-control requests (at most MAX_BURST beats each) plus data beats.
// A 2-entry prefetch buffer with a bypass for the returning BRAM word keeps
// the write channel at one beat per cycle.
// Optional build macro STORE_OUT_STALL_CNT_EN adds the stall_cnt output.
module store_output_dma
    import tpu_dma_pkg::*;
#(
    parameter int         DMA_DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH     = 5,
    parameter int         MAX_BURST      = 16,
    parameter logic [2:0] DMA_SIZE       = DMA_SIZE_32BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [95:0]               conf_regs,
    output logic                      busy,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     rd_addr,
    input  logic [DMA_DATA_WIDTH-1:0] rd_data,
    output logic                      write_ctrl_valid,
    input  logic                      write_ctrl_ready,
    output logic [CTRL_W-1:0]         write_ctrl_data,
    output logic                      write_chnl_valid,
    input  logic                      write_chnl_ready,
    output logic [DMA_DATA_WIDTH-1:0] write_chnl_data,
    output logic                      done
`ifdef STORE_OUT_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

    store_state_t              state;
    store_state_t              state_nx;
    logic [31:0]               remaining;
    logic [31:0]               cur_index;
    logic [31:0]               burst_len;
    logic [31:0]               burst_left;
    logic [31:0]               rd_issued;
    logic                      rd_vld_p1;
    logic [1:0]                fifo_cnt;
    logic [DMA_DATA_WIDTH-1:0] fifo_head;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      start_ok;
    logic                      ctrl_hs;
    logic                      chnl_hs;
    logic                      last_beat;
    logic [31:0]               conf_len;
    logic                      unused_conf;

    assign conf_len    = conf_regs[CONF_LEN_LSB +: 32];
    assign unused_conf = ^conf_regs;

    assign burst_len = burst_min(remaining, MAX_BURST_W);
    assign start_ok  = start && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FIN);

    assign write_ctrl_valid = (state == ST_REQ);
    assign ctrl_hs          = write_ctrl_valid && write_ctrl_ready;

    // Head of buffer, or the word returning from BRAM this cycle when empty
    assign write_chnl_valid = (state == ST_DATA) && ((fifo_cnt != 2'd0) || rd_vld_p1);
    assign chnl_hs          = write_chnl_valid && write_chnl_ready;
    assign write_chnl_data  = !write_chnl_valid ? '0 :
                              (fifo_cnt != 2'd0) ? fifo_head : rd_data;
    assign fifo_pop         = chnl_hs && (fifo_cnt != 2'd0);
    assign fifo_push        = rd_vld_p1 && !(chnl_hs && (fifo_cnt == 2'd0));
    assign last_beat        = chnl_hs && (burst_left == 32'd1);

    assign rd_en = ((state == ST_REQ) || (state == ST_DATA)) &&
                   (({1'b0, fifo_cnt} + {2'b00, rd_vld_p1}) < 3'd2) &&
                   (rd_issued < burst_len);

    // Control request packing; zero whenever no request is offered
    always_comb begin
        write_ctrl_data = '0;
        if (write_ctrl_valid) begin
            write_ctrl_data[CTRL_SIZE_LSB +: 3] = DMA_SIZE;
            write_ctrl_data[CTRL_LEN_LSB +: 32] = burst_len;
            write_ctrl_data[CTRL_IDX_LSB +: 32] = cur_index;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = (conf_len != 32'd0) ? ST_REQ : ST_FIN;
            ST_REQ:  if (ctrl_hs) state_nx = ST_DATA;
            ST_DATA: if (last_beat) state_nx = ((remaining - burst_len) != 32'd0) ? ST_REQ : ST_FIN;
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Control state: FSM, read address, read tracking (p0 issue -> p1 return)
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_vld_p1 <= 1'b0;
            rd_addr   <= '0;
            rd_issued <= 32'd0;
        end else begin
            state     <= state_nx;
            rd_vld_p1 <= rd_en;
            if (start_ok)
                rd_addr <= conf_regs[CONF_BASE_LSB +: ADDR_WIDTH];
            else if (rd_en)
                rd_addr <= rd_addr + 1'b1;
            if (start_ok || last_beat)
                rd_issued <= 32'd0;
            else if (rd_en)
                rd_issued <= rd_issued + 32'd1;
        end
    end

    // Descriptor bookkeeping; only meaningful while busy so not reset
    always_ff @(posedge clk) begin
        if (start_ok) begin
            remaining <= conf_len;
            cur_index <= conf_regs[CONF_IDX_LSB +: 32];
        end else if (last_beat) begin
            remaining <= remaining - burst_len;
            cur_index <= cur_index + burst_len;
        end
        if (ctrl_hs)
            burst_left <= burst_len;
        else if (chnl_hs)
            burst_left <= burst_left - 32'd1;
    end

    store_skid_fifo #(
        .DATA_W (DMA_DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rd_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

`ifdef STORE_OUT_STALL_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Back-pressure counter: cycles a beat was offered but not taken
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 32'd0;
        else if (start_ok)
            stall_cnt <= 32'd0;
        else if (write_chnl_valid && !write_chnl_ready)
            stall_cnt <= sat_inc32(stall_cnt);
    end
`else
    // Stall counter not built
`endif

endmodule
